// File: rtl/mcb_ref_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mcb_ref_seq
//  Description : Refresh command sequencer for the MCB back-end. On an
//                accepted refresh request it takes the SDRAM command bus,
//                closes open banks with PRECHARGE ALL, then issues a burst
//                of AUTO REFRESH commands spaced by tRP / tRFC. Every
//                command and status output is registered.
//  Revision    : 1.0  initial release
// ============================================================================
module mcb_ref_seq #(
    parameter int CtRP      = 3,   // PRECHARGE ALL -> first AUTO REFRESH (>=1)
    parameter int CtRFC     = 7,   // AUTO REFRESH -> next command / release (>=2)
    parameter int REF_BURST = 1,   // AUTO REFRESH commands per request (1..15)
    parameter int T_CNT_W   = 8    // timer width, holds max(CtRP, CtRFC)
) (
    input  logic mcb_clk,
    input  logic mcb_rst_n,
    input  logic mcb_sclr_n,
    input  logic r_ref_req,
    input  logic bank_open,
    output logic ref_busy,
    output logic ref_cs_n,
    output logic ref_ras_n,
    output logic ref_cas_n,
    output logic ref_we_n,
    output logic ref_a10,
    output logic c_ref,
    output logic ref_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_TRP  = 3'd2,
        S_AREF = 3'd3,
        S_TRFC = 3'd4
    } state_t;

    // Command encodings: {cs_n, ras_n, cas_n, we_n, a10}
    localparam logic [4:0] c_CMD_PRE_ALL = 5'b00101;
    localparam logic [4:0] c_CMD_AREF    = 5'b00010;
    localparam logic [4:0] c_CMD_DESEL   = 5'b11110;

    localparam logic [T_CNT_W-1:0] c_TRP_LOAD  = T_CNT_W'(CtRP);
    localparam logic [T_CNT_W-1:0] c_TRFC_LOAD = T_CNT_W'(CtRFC);
    localparam logic [T_CNT_W-1:0] c_T_ONE     = T_CNT_W'(1);
    localparam logic [3:0]         c_BURST     = 4'(REF_BURST);

    state_t               r_state;
    state_t               w_nxt;
    logic [T_CNT_W-1:0]   r_timer;
    logic [T_CNT_W-1:0]   w_timer_nxt;
    logic [3:0]           r_burst;
    logic [3:0]           w_burst_nxt;
    logic [4:0]           w_cmd_nxt;
    logic                 w_done_nxt;

    // The timer holds the cycles remaining in the current command slot,
    // counting the command cycle itself; at 1 the slot ends on this edge.
    logic w_slot_end;
    assign w_slot_end = (r_timer <= c_T_ONE);

    // Next-state, timer/burst updates and the command to present next cycle
    always_comb begin
        w_nxt       = r_state;
        w_timer_nxt = (r_timer == '0) ? '0 : r_timer - 1'b1;
        w_burst_nxt = r_burst;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ref_req) begin
                    w_nxt       = bank_open ? S_PRE : S_AREF;
                    w_burst_nxt = c_BURST;
                end
            end
            S_PRE: begin
                // CtRP == 1 skips the DESEL gap entirely
                w_nxt = w_slot_end ? S_AREF : S_TRP;
            end
            S_TRP: begin
                if (w_slot_end) begin
                    w_nxt = S_AREF;
                end
            end
            S_AREF: begin
                w_nxt       = S_TRFC;
                w_burst_nxt = (r_burst == 4'd0) ? 4'd0 : r_burst - 4'd1;
            end
            S_TRFC: begin
                if (w_slot_end) begin
                    if (r_burst != 4'd0) begin
                        w_nxt = S_AREF;
                    end else begin
                        w_nxt      = S_IDLE;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase

        // Timer is reloaded only when a timed command is entered
        if (w_nxt == S_PRE) begin
            w_timer_nxt = c_TRP_LOAD;
        end else if (w_nxt == S_AREF) begin
            w_timer_nxt = c_TRFC_LOAD;
        end

        case (w_nxt)
            S_PRE:   w_cmd_nxt = c_CMD_PRE_ALL;
            S_AREF:  w_cmd_nxt = c_CMD_AREF;
            default: w_cmd_nxt = c_CMD_DESEL;
        endcase
    end

    // State register; a synchronous clear aborts any sequence in progress
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            r_state <= S_IDLE;
        end else if (!mcb_sclr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Timer, burst count and registered command/status outputs
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            r_timer   <= '0;
            r_burst   <= 4'd0;
            ref_busy  <= 1'b0;
            ref_cs_n  <= 1'b1;
            ref_ras_n <= 1'b1;
            ref_cas_n <= 1'b1;
            ref_we_n  <= 1'b1;
            ref_a10   <= 1'b0;
            c_ref     <= 1'b0;
            ref_done  <= 1'b0;
        end else if (!mcb_sclr_n) begin
            r_timer   <= '0;
            r_burst   <= 4'd0;
            ref_busy  <= 1'b0;
            ref_cs_n  <= 1'b1;
            ref_ras_n <= 1'b1;
            ref_cas_n <= 1'b1;
            ref_we_n  <= 1'b1;
            ref_a10   <= 1'b0;
            c_ref     <= 1'b0;
            ref_done  <= 1'b0;
        end else begin
            r_timer   <= w_timer_nxt;
            r_burst   <= w_burst_nxt;
            ref_busy  <= (w_nxt != S_IDLE);
            ref_cs_n  <= w_cmd_nxt[4];
            ref_ras_n <= w_cmd_nxt[3];
            ref_cas_n <= w_cmd_nxt[2];
            ref_we_n  <= w_cmd_nxt[1];
            ref_a10   <= w_cmd_nxt[0];
            c_ref     <= (w_nxt == S_AREF);
            ref_done  <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire
